// File: rtl/feature_quantize_packer.sv
// Quantizes raw signed feature samples to Q_BITS codes and packs N_FEAT of them
// into one vector for layer 0, with a one-vector skid buffer toward the layer side.
module feature_quantize_packer #(
    parameter int N_FEAT = 8,
    parameter int IN_W   = 16,
    parameter int Q_BITS = 2,
    parameter int SHIFT  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_W-1:0]            s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [N_FEAT*Q_BITS-1:0]   m_data,
    output logic                       err_len
);

    localparam int VEC_W = N_FEAT * Q_BITS;
    localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(N_FEAT - 1);
    localparam logic signed [IN_W:0] BIAS     = (IN_W+1)'(2 ** (Q_BITS - 1));
    localparam logic signed [IN_W:0] QMAX     = (IN_W+1)'(2 ** Q_BITS - 1);

    // S_INIT keeps s_ready low for the first clock after reset release.
    typedef enum logic [1:0] {S_INIT, S_FILL, S_FULL, S_DISC} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   asm_q, asm_d, asm_ins;
    logic [VEC_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;

    logic signed [IN_W:0] q_ext, q_shift, q_bias;
    logic [Q_BITS-1:0]    code;
    logic                 accept, last_slot, out_free;

    always_comb begin
        q_ext   = {s_data[IN_W-1], s_data};
        q_shift = q_ext >>> SHIFT;
        q_bias  = q_shift + BIAS;
        if (q_bias[IN_W])
            code = '0;
        else if (q_bias > QMAX)
            code = QMAX[Q_BITS-1:0];
        else
            code = q_bias[Q_BITS-1:0];
    end

    // Assembly contents with the current sample's code dropped into slot cnt.
    generate
        for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_slot
            assign asm_ins[gi*Q_BITS +: Q_BITS] =
                (cnt_q == CNT_W'(gi)) ? code : asm_q[gi*Q_BITS +: Q_BITS];
        end
    endgenerate

    assign accept    = s_valid & s_ready;
    assign last_slot = (cnt_q == LAST_CNT);
    assign out_free  = ~out_valid_q | m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        err_d       = 1'b0;
        out_valid_d = out_valid_q & ~m_ready;
        out_data_d  = out_data_q;
        case (state_q)
            S_INIT: state_d = S_FILL;
            S_FILL: begin
                if (accept) begin
                    if (last_slot && s_last) begin
                        cnt_d = '0;
                        // A free (or draining) output takes the vector directly.
                        if (out_free) begin
                            out_valid_d = 1'b1;
                            out_data_d  = asm_ins;
                        end else begin
                            asm_d   = asm_ins;
                            state_d = S_FULL;
                        end
                    end else if (last_slot) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_DISC;
                    end else if (s_last) begin
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        asm_d = asm_ins;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_FULL: begin
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = asm_q;
                    state_d     = S_FILL;
                end
            end
            S_DISC: begin
                if (accept && s_last)
                    state_d = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        s_ready = (state_q == S_FILL) || (state_q == S_DISC);
        m_valid = out_valid_q;
        m_data  = out_data_q;
        err_len = err_q;
    end

endmodule

// File: tb/tb_feature_quantize_packer.sv
// Directed bench for feature_quantize_packer: quantizer corners, streaming,
// backpressure, short/long vector errors and asynchronous reset.
module tb_feature_quantize_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, s_last;
    logic [15:0] s_data;
    logic        m_valid, m_ready, err_len;
    logic [15:0] m_data;

    int errors = 0;
    int checks = 0;

    feature_quantize_packer #(.N_FEAT(8), .IN_W(16), .Q_BITS(2), .SHIFT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One accepted sample; returns 1 time unit after the clock edge.
    task automatic drive(input logic [15:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
    endtask

    // Raw sample that quantizes to the given code: codes 0..3 map to -512,-256,0,256.
    function automatic logic [15:0] raw_of(input int code);
        return 16'((code - 2) * 256);
    endfunction

    task automatic send_vec(input logic [15:0] codes);
        for (int i = 0; i < 8; i++)
            drive(raw_of(int'(codes[2*i +: 2])), i == 7);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [15:0] corner [8];
    logic [15:0] vec_a, vec_b, exp_v;

    initial begin
        corner[0] = 16'd0;      corner[1] = 16'd256;   corner[2] = 16'hFF00; corner[3] = 16'hFE00;
        corner[4] = 16'h7FFF;   corner[5] = 16'h8000;  corner[6] = 16'd255;  corner[7] = 16'hFFFF;
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err_len", err_len, 0);
        #10 rst_n = 1'b1;
        chk("init_s_ready_low", s_ready, 0);
        idle(1);
        chk("fill_s_ready", s_ready, 1);

        // Quantizer corners
        for (int i = 0; i < 8; i++) begin
            drive(corner[i], i == 7);
            if (i == 6) chk("corner_no_early_valid", m_valid, 0);
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("corner_m_valid", m_valid, 1);
        chk("corner_m_data", m_data, 16'b01_10_00_11_00_01_11_10);
        idle(1);
        chk("corner_drained", m_valid, 0);

        // Streaming: 3 vectors back to back
        for (int v = 0; v < 3; v++) begin
            exp_v = '0;
            for (int i = 0; i < 8; i++) begin
                exp_v[2*i +: 2] = 2'((i + v) % 4);
                chk("stream_s_ready", s_ready, 1);
                drive(raw_of((i + v) % 4), i == 7);
                chk("stream_m_valid", m_valid, (i == 7) ? 1 : 0);
                chk("stream_err_len", err_len, 0);
            end
            chk("stream_m_data", m_data, exp_v);
        end
        s_valid = 1'b0; s_last = 1'b0;
        idle(1);

        // Backpressure
        m_ready = 1'b0;
        vec_a = 16'b11_10_01_00_11_10_01_00;
        vec_b = 16'b00_01_10_11_00_01_10_11;
        send_vec(vec_a);
        chk("bp_a_valid", m_valid, 1);
        chk("bp_fill_ready", s_ready, 1);
        send_vec(vec_b);
        chk("bp_full_ready", s_ready, 0);
        idle(3);
        chk("bp_hold_data", m_data, vec_a);
        chk("bp_hold_valid", m_valid, 1);
        chk("bp_hold_ready", s_ready, 0);
        m_ready = 1'b1;
        idle(1);
        chk("bp_b_valid", m_valid, 1);
        chk("bp_b_data", m_data, vec_b);
        chk("bp_ready_back", s_ready, 1);
        idle(1);
        chk("bp_b_drained", m_valid, 0);

        // Short vector: s_last on 5th sample
        for (int i = 0; i < 5; i++) drive(raw_of(3), i == 4);
        s_valid = 1'b0; s_last = 1'b0;
        chk("short_err", err_len, 1);
        chk("short_no_valid", m_valid, 0);
        idle(1);
        chk("short_err_width", err_len, 0);
        vec_a = 16'b10_10_01_01_00_00_11_11;
        send_vec(vec_a);
        chk("short_next_data", m_data, vec_a);
        chk("short_next_valid", m_valid, 1);
        idle(1);

        // Long vector: 8 samples without s_last, then 3 discarded samples
        for (int i = 0; i < 8; i++) drive(raw_of(1), 1'b0);
        chk("long_err", err_len, 1);
        chk("long_no_valid", m_valid, 0);
        for (int i = 0; i < 3; i++) begin
            drive(raw_of(2), i == 2);
            chk("long_disc_err", err_len, 0);
            chk("long_disc_valid", m_valid, 0);
        end
        s_valid = 1'b0; s_last = 1'b0;
        vec_b = 16'b01_11_00_10_01_11_00_10;
        send_vec(vec_b);
        chk("long_next_valid", m_valid, 1);
        chk("long_next_data", m_data, vec_b);
        idle(1);

        // Asynchronous reset mid-vector with an output held
        m_ready = 1'b0;
        send_vec(16'hFFFF);
        for (int i = 0; i < 3; i++) drive(raw_of(0), 1'b0);
        s_valid = 1'b0;
        chk("ar_pre_valid", m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_m_valid", m_valid, 0);
        chk("ar_s_ready", s_ready, 0);
        chk("ar_m_data", m_data, 0);
        idle(2);
        #2 rst_n = 1'b1;
        m_ready = 1'b1;
        idle(1);
        chk("ar_ready_back", s_ready, 1);
        chk("ar_no_err", err_len, 0);
        vec_a = 16'b00_11_01_10_10_01_11_00;
        send_vec(vec_a);
        chk("ar_fresh_valid", m_valid, 1);
        chk("ar_fresh_data", m_data, vec_a);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/feature_quantize_packer.md
# feature_quantize_packer

Streaming input stage ahead of the first sparse LUT layer. It accepts raw signed feature samples one per handshake, quantizes each one to a Q_BITS unsigned code, and packs N_FEAT codes into the flat input vector that layer 0 neurons slice their fan-in bits from. It is the producer end of the packed-code bus that the layer-0 neuron ROMs consume, and it decouples the upstream sample stream from the network with a one-vector skid buffer.

## Interface
- N_FEAT, 8, features per vector
- IN_W, 16, raw feature width, two's complement
- Q_BITS, 2, code width per feature
- SHIFT, 8, arithmetic right-shift applied before clamping
- Ports:
  - clk  in  1  rising-edge clock
  - rst_n  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
  - s_valid  in  1  raw sample valid
  - s_ready  out  1  packer can accept a sample
  - s_data  in  IN_W  raw signed feature
  - s_last  in  1  marks the final feature of a vector
  - m_valid  out  1  packed vector valid
  - m_ready  in  1  layer side accepts the vector
  - m_data  out  N_FEAT*Q_BITS  packed codes; feature i at bits [i*Q_BITS +: Q_BITS], feature 0 in the LSBs
  - err_len  out  1  one-cycle pulse: malformed vector dropped

## Operation
- Quantization, combinational per sample: t = s_data >>> SHIFT (signed, arithmetic); c = t + 2^(Q_BITS-1); code = clamp(c, 0, 2^Q_BITS-1). Intermediate width IN_W+1 signed, so no overflow.
- Assembly register (N_FEAT*Q_BITS) plus feature counter cnt (0..N_FEAT-1). An accepted sample writes its code to slot cnt.
- Output register holds m_data/m_valid. It is loaded from assembly when a vector completes and the output is empty, or in the same cycle it is being drained (m_valid & m_ready).
- State machine:
  - FILL: s_ready=1. On accept with cnt<N_FEAT-1 and !s_last: cnt++. On accept with cnt==N_FEAT-1 and s_last: vector complete; cnt<=0. If the output is free this cycle, load it and stay in FILL; else go to FULL.
  - FULL: s_ready=0. When the output frees, load assembly to output and go to FILL.
  - DISCARD: s_ready=1. Samples are accepted and dropped. An accept with s_last moves to FILL with cnt=0.
- Length errors, each causing an err_len pulse on the next cycle:
  - Accept with s_last and cnt<N_FEAT-1: partial vector dropped, cnt<=0, stay in FILL.
  - Accept with cnt==N_FEAT-1 and !s_last: vector dropped, go to DISCARD.
- The output register holds m_data stable while m_valid=1 and m_ready=0.
- Reset mid-vector: the partial vector and any held output are lost, with no err_len.

## Timing
- Reset values: s_ready=0 while rst_n=0, then 1 (FILL) from the first clock after release; m_valid=0, m_data=0, err_len=0, cnt=0.
- Latency: m_valid rises 1 cycle after the accept of the last feature when the output is free.
- Throughput: one sample per cycle sustained, with no bubble between vectors while m_ready=1.
- Back-to-back: a vector completing in the same cycle as the output drains loads directly, and m_valid stays 1.
- Backpressure: a completed vector waits in FULL. s_ready drops the cycle after completion and returns the cycle after the output drains.
- err_len is exactly 1 cycle wide per dropped vector.

## Test plan
- Quantizer corners, N_FEAT=8/Q_BITS=2/SHIFT=8: features 0, 256, -256, -512, 32767, -32768, 255, -1 -> m_data codes 2,3,1,0,3,0,2,1 (m_data=16'b01_10_00_11_00_01_11_10). m_valid rises 1 cycle after the 8th accept.
- Streaming: 3 vectors of 8 samples, s_valid and m_ready held 1 -> s_ready never drops, 3 m_valid pulses spaced 8 cycles apart, no err_len.
- Backpressure: m_ready=0 while 2 full vectors are sent -> the second completes and s_ready drops to 0. Raise m_ready -> vector 1 then vector 2 each appear with stable m_data. s_ready returns to 1 the cycle after the first drain.
- Short vector: s_last on the 5th sample -> err_len pulse, no m_valid. The next 8-sample vector packs correctly from slot 0.
- Long vector: 8 samples without s_last -> err_len, then 3 extra samples ending with s_last are dropped. The next valid vector emerges normally.
- Async reset: assert rst_n=0 mid-vector with m_valid=1 -> m_valid and s_ready go 0 immediately, without waiting for a clock edge. After release, a fresh vector packs correctly.
